// File: rtl/shmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shmem_arbiter
// Purpose  : Round-robin arbiter that shares the single write port and the
//            single read port of shared_memory among N_UNITS requesters.
//            Each cycle it grants at most one push and one pop. Memory-side
//            signals come from registers. Read data returns to the winning
//            unit after a fixed RD_LAT pipeline delay.
// Options  : `SHMEM_ARB_FWD_EN enables write-to-read forwarding. When a pop
//            and a push hit the same slot in the same issue cycle, the pop
//            returns the newly written word instead of the old contents.
// Revision : 1.0 - initial release
// ============================================================================
module shmem_arbiter #(
    parameter int  N_UNITS = 32,
    parameter int  DW      = 512,
    parameter int  RD_LAT  = 1,
    localparam int IW      = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_UNITS-1:0]    push_req,
    input  logic [N_UNITS*IW-1:0] push_dst_id,
    input  logic [N_UNITS*DW-1:0] push_data,
    output logic [N_UNITS-1:0]    push_gnt,
    input  logic [N_UNITS-1:0]    pop_req,
    input  logic [N_UNITS*IW-1:0] pop_src_id,
    output logic [N_UNITS-1:0]    pop_gnt,
    output logic [N_UNITS-1:0]    pop_valid,
    output logic [DW-1:0]         pop_data,
    output logic                  mem_write_enable,
    output logic [IW-1:0]         mem_write_unit_id,
    output logic [DW-1:0]         mem_write_data,
    output logic [IW-1:0]         mem_read_unit_id,
    input  logic [DW-1:0]         mem_read_data
);

    localparam logic [N_UNITS-1:0] c_onehot0 = N_UNITS'(1);
    localparam logic [IW-1:0]      c_last_id = IW'(N_UNITS - 1);

    // First requester at or after ptr, searching modulo N_UNITS; {found, index}
    function automatic logic [IW:0] rr_pick(input logic [N_UNITS-1:0] req,
                                            input logic [IW-1:0]      ptr);
        logic          found;
        logic [IW-1:0] win;
        int            idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_UNITS) begin
                idx = idx - N_UNITS;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        return {found, win};
    endfunction

    // Pointer moves one past the winner, wrapping the last unit back to 0
    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] win);
        return (win == c_last_id) ? '0 : win + 1'b1;
    endfunction

    logic [IW-1:0] r_push_ptr;
    logic [IW-1:0] r_pop_ptr;
    logic [IW:0]   w_push_pick;
    logic [IW:0]   w_pop_pick;
    logic          w_push_any;
    logic          w_pop_any;
    logic [IW-1:0] w_push_win;
    logic [IW-1:0] w_pop_win;

    assign w_push_pick = rr_pick(push_req, r_push_ptr);
    assign w_pop_pick  = rr_pick(pop_req, r_pop_ptr);
    assign w_push_any  = w_push_pick[IW] & rst_n;
    assign w_pop_any   = w_pop_pick[IW] & rst_n;
    assign w_push_win  = w_push_pick[IW-1:0];
    assign w_pop_win   = w_pop_pick[IW-1:0];

    // Grants are combinational and suppressed while reset is asserted
    assign push_gnt = w_push_any ? (c_onehot0 << w_push_win) : '0;
    assign pop_gnt  = w_pop_any  ? (c_onehot0 << w_pop_win)  : '0;

    // Round-robin pointers advance only on a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push_ptr <= '0;
            r_pop_ptr  <= '0;
        end else begin
            if (w_push_any) begin
                r_push_ptr <= rr_next(w_push_win);
            end
            if (w_pop_any) begin
                r_pop_ptr <= rr_next(w_pop_win);
            end
        end
    end

    // Push stage: one write strobe per grant, carrying the winner's slot and word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write_enable  <= 1'b0;
            mem_write_unit_id <= '0;
            mem_write_data    <= '0;
        end else begin
            mem_write_enable <= w_push_any;
            if (w_push_any) begin
                mem_write_unit_id <= push_dst_id[int'(w_push_win)*IW +: IW];
                mem_write_data    <= push_data[int'(w_push_win)*DW +: DW];
            end
        end
    end

    logic          r_iss_vld;
    logic [IW-1:0] r_iss_idx;

    // Pop issue stage: drive the read slot and remember who asked for it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_vld        <= 1'b0;
            r_iss_idx        <= '0;
            mem_read_unit_id <= '0;
        end else begin
            r_iss_vld <= w_pop_any;
            if (w_pop_any) begin
                r_iss_idx        <= w_pop_win;
                mem_read_unit_id <= pop_src_id[int'(w_pop_win)*IW +: IW];
            end
        end
    end

    logic          w_fin_vld;
    logic [IW-1:0] w_fin_idx;
`ifdef SHMEM_ARB_FWD_EN
    logic          w_fwd_hit;
    logic          w_fin_fwd;
    logic [DW-1:0] w_fin_fdata;

    // Same-slot write and read in the issue cycle: return the new word
    assign w_fwd_hit = mem_write_enable && (mem_write_unit_id == mem_read_unit_id);
`endif

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign w_fin_vld = r_iss_vld;
            assign w_fin_idx = r_iss_idx;
`ifdef SHMEM_ARB_FWD_EN
            assign w_fin_fwd   = w_fwd_hit;
            assign w_fin_fdata = mem_write_data;
`endif
        end else begin : g_latn
            logic [RD_LAT-1:0] r_dly_vld;
            logic [IW-1:0]     r_dly_idx [RD_LAT];
`ifdef SHMEM_ARB_FWD_EN
            logic [RD_LAT-1:0] r_dly_fwd;
            logic [DW-1:0]     r_dly_fdata [RD_LAT];
`endif
            // Requester index (and forwarded word) track the memory read latency
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly_vld <= '0;
                    for (int k = 0; k < RD_LAT; k++) begin
                        r_dly_idx[k] <= '0;
                    end
`ifdef SHMEM_ARB_FWD_EN
                    r_dly_fwd <= '0;
                    for (int k = 0; k < RD_LAT; k++) begin
                        r_dly_fdata[k] <= '0;
                    end
`endif
                end else begin
                    r_dly_vld[0] <= r_iss_vld;
                    r_dly_idx[0] <= r_iss_idx;
                    for (int k = 1; k < RD_LAT; k++) begin
                        r_dly_vld[k] <= r_dly_vld[k-1];
                        r_dly_idx[k] <= r_dly_idx[k-1];
                    end
`ifdef SHMEM_ARB_FWD_EN
                    r_dly_fwd[0]   <= w_fwd_hit;
                    r_dly_fdata[0] <= mem_write_data;
                    for (int k = 1; k < RD_LAT; k++) begin
                        r_dly_fwd[k]   <= r_dly_fwd[k-1];
                        r_dly_fdata[k] <= r_dly_fdata[k-1];
                    end
`endif
                end
            end
            assign w_fin_vld = r_dly_vld[RD_LAT-1];
            assign w_fin_idx = r_dly_idx[RD_LAT-1];
`ifdef SHMEM_ARB_FWD_EN
            assign w_fin_fwd   = r_dly_fwd[RD_LAT-1];
            assign w_fin_fdata = r_dly_fdata[RD_LAT-1];
`endif
        end
    endgenerate

    // Return stage: capture read data and pulse the owner's valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid <= '0;
            pop_data  <= '0;
        end else begin
            pop_valid <= w_fin_vld ? (c_onehot0 << w_fin_idx) : '0;
            if (w_fin_vld) begin
`ifdef SHMEM_ARB_FWD_EN
                pop_data <= w_fin_fwd ? w_fin_fdata : mem_read_data;
`else
                pop_data <= mem_read_data;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shmem_arbiter
// Purpose  : Directed scoreboard bench for shmem_arbiter with a behavioural
//            shared_memory model (registered read, RD_LAT = 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shmem_arbiter;

    localparam int N      = 32;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;
    localparam int IW     = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    push_req;
    logic [N*IW-1:0] push_dst_id;
    logic [N*DW-1:0] push_data;
    logic [N-1:0]    push_gnt;
    logic [N-1:0]    pop_req;
    logic [N*IW-1:0] pop_src_id;
    logic [N-1:0]    pop_gnt;
    logic [N-1:0]    pop_valid;
    logic [DW-1:0]   pop_data;
    logic            mem_write_enable;
    logic [IW-1:0]   mem_write_unit_id;
    logic [DW-1:0]   mem_write_data;
    logic [IW-1:0]   mem_read_unit_id;
    logic [DW-1:0]   mem_read_data;

    shmem_arbiter #(.N_UNITS(N), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .push_req          (push_req),
        .push_dst_id       (push_dst_id),
        .push_data         (push_data),
        .push_gnt          (push_gnt),
        .pop_req           (pop_req),
        .pop_src_id        (pop_src_id),
        .pop_gnt           (pop_gnt),
        .pop_valid         (pop_valid),
        .pop_data          (pop_data),
        .mem_write_enable  (mem_write_enable),
        .mem_write_unit_id (mem_write_unit_id),
        .mem_write_data    (mem_write_data),
        .mem_read_unit_id  (mem_read_unit_id),
        .mem_read_data     (mem_read_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural shared_memory: write commits at the clock edge, one-cycle read
    logic [DW-1:0] mem [N];
    initial begin
        for (int i = 0; i < N; i++) mem[i] = '0;
        mem_read_data = '0;
    end
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_write_unit_id] <= mem_write_data;
        mem_read_data <= mem[mem_read_unit_id];
    end

    typedef struct {
        int            due;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } wr_t;
    typedef struct {
        int            due;
        int            unit;
        logic [DW-1:0] data;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int u);
        logic [N-1:0] v;
        v    = '0;
        v[u] = 1'b1;
        return v;
    endfunction

    task automatic exp_wr(input logic [IW-1:0] dst, input logic [DW-1:0] d);
        wq.push_back('{cyc + 1, dst, d});
    endtask

    task automatic exp_rd(input int u, input logic [DW-1:0] d);
        rq.push_back('{cyc + 2 + RD_LAT, u, d});
    endtask

    task automatic clr();
        push_req = '0;
        pop_req  = '0;
    endtask

    task automatic set_push(input int u, input int dst, input logic [DW-1:0] d);
        push_req[u]             = 1'b1;
        push_dst_id[u*IW +: IW] = IW'(dst);
        push_data[u*DW +: DW]   = d;
    endtask

    task automatic set_pop(input int u, input int src);
        pop_req[u]             = 1'b1;
        pop_src_id[u*IW +: IW] = IW'(src);
    endtask

    // Monitor: every write strobe / read return is matched against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_write_enable) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: got write slot %0d data %0h, required none", mem_write_unit_id, mem_write_data);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_slot", 64'(mem_write_unit_id), 64'(w.id));
                    chk("wr_data", 64'(mem_write_data), 64'(w.data));
                    chk("wr_cycle", 64'(cyc), 64'(w.due));
                end
            end
            if (pop_valid != '0) begin
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected: got pop_valid %0h data %0h, required none", pop_valid, pop_data);
                end else begin
                    rd_t r;
                    r = rq.pop_front();
                    chk("rd_valid", 64'(pop_valid), 64'(oh(r.unit)));
                    chk("rd_data", 64'(pop_data), 64'(r.data));
                    chk("rd_cycle", 64'(cyc), 64'(r.due));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    logic [DW-1:0] coll_exp;

    initial begin
        // Test 1: reset held with every request asserted
        push_req = '1;
        pop_req  = '1;
        for (int i = 0; i < N; i++) begin
            push_dst_id[i*IW +: IW] = IW'(i);
            push_data[i*DW +: DW]   = 32'hA000_0000 | DW'(i);
            pop_src_id[i*IW +: IW]  = IW'(N - 1 - i);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_push_gnt", 64'(push_gnt), 64'd0);
            chk("rst_pop_gnt", 64'(pop_gnt), 64'd0);
            chk("rst_pop_valid", 64'(pop_valid), 64'd0);
            chk("rst_pop_data", 64'(pop_data), 64'd0);
            chk("rst_wr_en", 64'(mem_write_enable), 64'd0);
            chk("rst_wr_slot", 64'(mem_write_unit_id), 64'd0);
            chk("rst_wr_data", 64'(mem_write_data), 64'd0);
            chk("rst_rd_slot", 64'(mem_read_unit_id), 64'd0);
        end
        // Release: both pointers at 0 pick unit 0
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_push_gnt", 64'(push_gnt), 64'(oh(0)));
        chk("rel_pop_gnt", 64'(pop_gnt), 64'(oh(0)));
        exp_wr(5'd0, 32'hA000_0000);
        exp_rd(0, 32'h0);

        // Test 2: single push by unit 1 to slot 1
        @(negedge clk);
        clr();
        set_push(1, 1, 32'h4000_0000);
        #1;
        chk("single_push_gnt", 64'(push_gnt), 64'h2);
        exp_wr(5'd1, 32'h4000_0000);
        @(negedge clk);
        clr();
        @(negedge clk);
        chk("single_wr_en_drop", 64'(mem_write_enable), 64'd0);

        // Test 3: units 0, 3, 31 push continuously; pointer sits at 2
        for (int c = 0; c < 9; c++) begin
            int eu;
            @(negedge clk);
            clr();
            set_push(0, 0, 32'hA000_0000);
            set_push(3, 3, 32'hA000_0003);
            set_push(31, 31, 32'hA000_001F);
            #1;
            eu = (c % 3 == 0) ? 3 : ((c % 3 == 1) ? 31 : 0);
            chk("rr_push_gnt", 64'(push_gnt), 64'(oh(eu)));
            exp_wr(IW'(eu), 32'hA000_0000 | DW'(eu));
        end

        // Test 4: unit 2 pops slot 1
        @(negedge clk);
        clr();
        set_pop(2, 1);
        #1;
        chk("pop_gnt_u2", 64'(pop_gnt), 64'(oh(2)));
        exp_rd(2, 32'h4000_0000);
        @(negedge clk);
        clr();
        chk("pop_rd_slot", 64'(mem_read_unit_id), 64'd1);
        repeat (3) @(negedge clk);
        // Back-to-back pops by units 2 then 4
        clr();
        set_pop(2, 1);
        #1;
        chk("b2b_gnt_u2", 64'(pop_gnt), 64'(oh(2)));
        exp_rd(2, 32'h4000_0000);
        @(negedge clk);
        clr();
        set_pop(4, 3);
        #1;
        chk("b2b_gnt_u4", 64'(pop_gnt), 64'(oh(4)));
        exp_rd(4, 32'hA000_0003);
        @(negedge clk);
        clr();
        repeat (3) @(negedge clk);

        // Test 5: slot 7 holds A, then push B and pop slot 7 together
        set_push(5, 7, 32'h1111_AAAA);
        #1;
        chk("coll_fill_gnt", 64'(push_gnt), 64'(oh(5)));
        exp_wr(5'd7, 32'h1111_AAAA);
        @(negedge clk);
        clr();
        set_push(0, 7, 32'h2222_BBBB);
        set_pop(1, 7);
        #1;
        chk("coll_push_gnt", 64'(push_gnt), 64'(oh(0)));
        chk("coll_pop_gnt", 64'(pop_gnt), 64'(oh(1)));
`ifdef SHMEM_ARB_FWD_EN
        coll_exp = 32'h2222_BBBB;
`else
        coll_exp = 32'h1111_AAAA;
`endif
        exp_wr(5'd7, 32'h2222_BBBB);
        exp_rd(1, coll_exp);
        @(negedge clk);
        clr();
        repeat (4) @(negedge clk);

        // Test 6: move both pointers, then reset one cycle after a pop grant
        set_push(4, 20, 32'h6666_0004);
        #1;
        chk("mid_push_gnt", 64'(push_gnt), 64'(oh(4)));
        exp_wr(5'd20, 32'h6666_0004);
        @(negedge clk);
        clr();
        set_pop(2, 1);
        #1;
        chk("mid_pop_gnt", 64'(pop_gnt), 64'(oh(2)));
        @(negedge clk);
        clr();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_slot", 64'(mem_read_unit_id), 64'd0);
        chk("mid_rst_pop_valid", 64'(pop_valid), 64'd0);
        @(negedge clk);
        chk("mid_rst_pop_valid2", 64'(pop_valid), 64'd0);
        @(negedge clk);
        // Pointers restart at 0: unit 1 must beat unit 5 (push) and unit 3 (pop)
        set_push(1, 1, 32'h7777_0001);
        set_push(5, 5, 32'h7777_0005);
        set_pop(1, 20);
        set_pop(3, 28);
        rst_n = 1'b1;
        #1;
        chk("post_rst_push_gnt", 64'(push_gnt), 64'(oh(1)));
        chk("post_rst_pop_gnt", 64'(pop_gnt), 64'(oh(1)));
        exp_wr(5'd1, 32'h7777_0001);
        exp_rd(1, 32'h6666_0004);
        @(negedge clk);
        clr();

        // Drain with a bounded wait
        for (int i = 0; i < 20 && (wq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drain_wr_queue", 64'(wq.size()), 64'd0);
        chk("drain_rd_queue", 64'(rq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
